freelist_ctrl: RTL

FREELIST_CTRL -- requirements
Module: freelist_ctrl

---
 rtl/freelist_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/freelist_ctrl.sv
// freelist_ctrl: physical-register freelist front end. Released registers
// are parked in a small circular staging buffer and trickled into the
// freelist FIFO one per cycle. When the FIFO is empty, allocation is served
// straight from the staging head.
module freelist_ctrl #(
  parameter int unsigned PREG_WIDTH  = 5,
  parameter int unsigned STAGE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_req_i,
  output logic                          alloc_ready_o,
  output logic [PREG_WIDTH-1:0]         alloc_preg_o,
  input  logic                          rel0_valid_i,
  input  logic [PREG_WIDTH-1:0]         rel0_preg_i,
  input  logic                          rel1_valid_i,
  input  logic [PREG_WIDTH-1:0]         rel1_preg_i,
  output logic                          rel_ready_o,
  input  logic                          drain_req_i,
  output logic                          drain_done_o,
  output logic                          fl_rd_en_o,
  input  logic [PREG_WIDTH-1:0]         fl_rdata_i,
  input  logic                          fl_empty_i,
  input  logic                          fl_full_i,
  output logic                          fl_wr_en_o,
  output logic [PREG_WIDTH-1:0]         fl_wdata_o,
  output logic [$clog2(STAGE_DEPTH):0]  stage_cnt_o
);

  localparam int unsigned PTR_W = $clog2(STAGE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Both lanes may fire only while at least two slots are free.
  localparam logic [CNT_W-1:0] REL_LIMIT = CNT_W'(STAGE_DEPTH - 2);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [PREG_WIDTH-1:0]  stage_q [STAGE_DEPTH];
  logic [PREG_WIDTH-1:0]  stage_d [STAGE_DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   is_run;
  logic                   has_stage;
  logic                   rel_ready;
  logic                   alloc_ready;
  logic                   alloc_fire;
  logic                   bypass;
  logic                   fifo_rd;
  logic                   fifo_wr;
  logic                   pop;
  logic                   enq0;
  logic                   enq1;
  logic [PREG_WIDTH-1:0]  head_entry;
  logic [PREG_WIDTH-1:0]  alloc_preg;
  logic [PREG_WIDTH-1:0]  wdata;

  // Handshakes, staging push/pop, next-state and output selection.
  always_comb begin
    is_run      = (state_q == ST_RUN);
    has_stage   = (count_q != '0);
    head_entry  = stage_q[head_q];

    rel_ready   = is_run && (count_q <= REL_LIMIT);
    alloc_ready = is_run && (!fl_empty_i || has_stage);
    alloc_fire  = alloc_req_i && alloc_ready;
    fifo_rd     = alloc_fire && !fl_empty_i;
    bypass      = alloc_fire && fl_empty_i;
    // Bypass takes the head this cycle, so the FIFO write must wait.
    fifo_wr     = !bypass && has_stage && !fl_full_i;
    pop         = bypass || fifo_wr;

    enq0        = rel_ready && rel0_valid_i;
    enq1        = rel_ready && rel1_valid_i;

    stage_d = stage_q;
    tail_d  = tail_q;
    if (enq0) begin
      stage_d[tail_d] = rel0_preg_i;
      tail_d          = tail_d + PTR_W'(1);
    end
    if (enq1) begin
      stage_d[tail_d] = rel1_preg_i;
      tail_d          = tail_d + PTR_W'(1);
    end

    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    count_d = count_q + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(pop);

    case (state_q)
      ST_INIT:  state_d = ST_RUN;
      ST_RUN:   state_d = drain_req_i ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = has_stage ? ST_DRAIN : ST_RUN;
      default:  state_d = ST_INIT;
    endcase

    alloc_preg = '0;
    if (is_run) begin
      if (!fl_empty_i) begin
        alloc_preg = fl_rdata_i;
      end else if (has_stage) begin
        alloc_preg = head_entry;
      end
    end
    wdata = has_stage ? head_entry : '0;
  end

  // State, pointers, count and staging storage; reset discards staged data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < STAGE_DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < STAGE_DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign alloc_ready_o = alloc_ready;
  assign alloc_preg_o  = alloc_preg;
  assign rel_ready_o   = rel_ready;
  assign fl_rd_en_o    = fifo_rd;
  assign fl_wr_en_o    = fifo_wr;
  assign fl_wdata_o    = wdata;
  assign drain_done_o  = (state_q == ST_DRAIN) && !has_stage;
  assign stage_cnt_o   = count_q;

endmodule
